// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the sequential binary-to-BCD converter.
//   DIGIT_W      : width of one BCD digit (4 bits)
//   ADD3_THRESH  : digits at or above this value get +3 before each shift
//   state_t      : converter FSM encoding (IDLE / SHIFT / DONE)
//   pow10()      : constant helper used for the elaboration-time size check
// -----------------------------------------------------------------------------
package bcd_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [3:0] ADD3_THRESH = 4'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
// Combinational double-dabble digit correction: out = in + 3 when in >= 5,
// otherwise out = in. Applied to every BCD digit before each left shift so
// the shift carries correctly into the next decimal digit.
// Ports:
//   din  [3:0] : current BCD digit
//   dout [3:0] : corrected digit
// -----------------------------------------------------------------------------
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  // din is at most 9 in normal operation, so din + 3 never exceeds 12 and
  // the 4-bit sum cannot wrap.
  assign dout = (din >= ADD3_THRESH) ? din + 4'd3 : din;

endmodule

// File: rtl/seq_bin2bcd.sv
// -----------------------------------------------------------------------------
// seq_bin2bcd
// Sequential shift-and-add-3 (double-dabble) converter from a W-bit unsigned
// binary value to ND packed BCD digits. One bit is processed per clock.
//
// Ports:
//   CLOCK_50      in   system clock, rising edge
//   Reset         in   synchronous active-high reset
//   Start         in   conversion request, sampled only while idle
//   Bin  [W-1:0]  in   operand, captured in the cycle Start is accepted
//   Busy          out  high from the cycle after acceptance through DONE
//   Done          out  one-cycle pulse; BCD holds the new result that cycle
//   BCD  [4ND-1:0] out packed result, digit k at [4k+3:4k], digit 0 = LSD
//   Blank [ND-1:0] out (only with BCD_LEADING_BLANK_EN) leading-zero flags,
//                      Blank[k]=1 when digits k..ND-1 are all zero (k>=1);
//                      Blank[0] is always 0
//
// Configuration macro: BCD_LEADING_BLANK_EN adds the Blank output.
//
// Handshake: Start is a request, not a valid/ready pair. It is honoured only
// in IDLE; any Start seen while Busy is dropped, not queued. Each accepted
// Start produces exactly one Done pulse W+1 cycles later unless Reset
// intervenes, in which case no Done is produced for it.
//
// Timing (Start accepted in cycle 0): SHIFT in cycles 1..W, DONE in W+1,
// next Start accepted no earlier than cycle W+2.
// -----------------------------------------------------------------------------
module seq_bin2bcd
  import bcd_pkg::*;
#(
  parameter int W  = 8,
  parameter int ND = 3
) (
  input  logic                  CLOCK_50,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [W-1:0]          Bin,
  output logic                  Busy,
  output logic                  Done,
  output logic [DIGIT_W*ND-1:0] BCD
`ifdef BCD_LEADING_BLANK_EN
  ,
  output logic [ND-1:0]         Blank
`endif
);

  localparam int BW = DIGIT_W * ND;
  localparam int CW = $clog2(W + 1);
  localparam longint unsigned MAX_BIN = (longint'(1) << W) - 1;

  // Parameter sanity checks at elaboration.
  if (W < 4 || W > 16) begin : g_bad_width
    $error("seq_bin2bcd: W must be in 4..16");
  end
  if (pow10(ND) <= MAX_BIN) begin : g_bad_digits
    $error("seq_bin2bcd: ND digits cannot hold 2^W-1");
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t          state;
  state_t          state_nxt;
  logic [W-1:0]    binreg;
  logic [BW-1:0]   scratch;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   bcd_q;

  // FSM control decoded from state
  logic            capture;
  logic            shift_en;
  logic            last_shift;

  // Corrected digits and the shifted scratch value for this cycle
  logic [BW-1:0]   scratch_adj;
  logic [BW-1:0]   scratch_sh;

  // ---------------------------------------------------------------------------
  // Per-digit add-3 correction
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < ND; k++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (scratch[k*DIGIT_W +: DIGIT_W]),
      .dout (scratch_adj[k*DIGIT_W +: DIGIT_W])
    );
  end

  // The MSB of the binary register enters the BCD scratch on every shift.
  assign scratch_sh = {scratch_adj[BW-2:0], binreg[W-1]};
  assign last_shift = (cnt == CW'(1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    shift_en  = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (Start) begin
          capture   = 1'b1;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        Busy     = 1'b1;
        shift_en = 1'b1;
        if (last_shift) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        Busy      = 1'b1;
        Done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // The output register is loaded on the edge that enters DONE so that the new
  // BCD value and the Done pulse appear in the same cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      binreg  <= '0;
      scratch <= '0;
      cnt     <= '0;
      bcd_q   <= '0;
    end else if (capture) begin
      binreg  <= Bin;
      scratch <= '0;
      cnt     <= CW'(W);
    end else if (shift_en) begin
      binreg  <= {binreg[W-2:0], 1'b0};
      scratch <= scratch_sh;
      cnt     <= cnt - CW'(1);
      if (last_shift) begin
        bcd_q <= scratch_sh;
      end
    end
  end

  assign BCD = bcd_q;

`ifdef BCD_LEADING_BLANK_EN
  // ---------------------------------------------------------------------------
  // Leading-zero blanking, computed from the same final value as BCD.
  // Digit 0 is never blanked so zero still shows a single "0".
  // ---------------------------------------------------------------------------
  localparam logic [ND-1:0] BLANK_RST = ~(ND'(1));

  logic [ND-1:0] blank_nxt;
  logic [ND-1:0] blank_q;
  logic          zero_run;

  always_comb begin
    blank_nxt = '0;
    zero_run  = 1'b1;
    for (int k = ND - 1; k >= 1; k--) begin
      zero_run     = zero_run && (scratch_sh[k*DIGIT_W +: DIGIT_W] == '0);
      blank_nxt[k] = zero_run;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      blank_q <= BLANK_RST;
    end else if (shift_en && last_shift) begin
      blank_q <= blank_nxt;
    end
  end

  assign Blank = blank_q;
`endif

`ifndef SYNTHESIS
  // A digit of 10 or more after a shift means the add-3 correction failed.
  always @(posedge CLOCK_50) begin
    if (!Reset && shift_en) begin
      for (int k = 0; k < ND; k++) begin
        assert (scratch_sh[k*DIGIT_W +: DIGIT_W] <= 4'd9);
      end
    end
  end
`endif

endmodule

// File: tb/tb_seq_bin2bcd.sv
// -----------------------------------------------------------------------------
// tb_seq_bin2bcd
// Self-checking bench for seq_bin2bcd (W = 8, ND = 3). Expected BCD values are
// computed from the operand by repeated divide-by-10 and queued when a
// conversion is started; they are popped and compared on each Done pulse.
// -----------------------------------------------------------------------------
module tb_seq_bin2bcd;

  localparam int W   = 8;
  localparam int ND  = 3;
  localparam int BW  = 4 * ND;
  localparam int TO  = 40;    // cycle budget for any single conversion
  localparam int LAT = W + 1; // cycles from acceptance to Done

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  bin;
  logic          busy;
  logic          done;
  logic [BW-1:0] bcd;
`ifdef BCD_LEADING_BLANK_EN
  logic [ND-1:0] blank;
`endif

  logic [BW-1:0] exp_q[$];
  int            n_cmp = 0;
  int            n_err = 0;

  // ---------------------------------------------------------------------------
  // Clock / DUT
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  seq_bin2bcd #(.W(W), .ND(ND)) dut (
    .CLOCK_50 (clk),
    .Reset    (reset),
    .Start    (start),
    .Bin      (bin),
    .Busy     (busy),
    .Done     (done),
    .BCD      (bcd)
`ifdef BCD_LEADING_BLANK_EN
    ,
    .Blank    (blank)
`endif
  );

  // ---------------------------------------------------------------------------
  // Reference model: decimal digits of v, least significant first
  // ---------------------------------------------------------------------------
  function automatic logic [BW-1:0] model_bcd(input int v);
    logic [BW-1:0] r;
    int            x;
    r = '0;
    x = v;
    for (int k = 0; k < ND; k++) begin
      r[k*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // drive_start returns at the falling edge of cycle 1 (acceptance = cycle 0).
  // ---------------------------------------------------------------------------
  task automatic drive_start(input logic [W-1:0] v);
    @(negedge clk);
    start = 1'b1;
    bin   = v;
    exp_q.push_back(model_bcd(int'(v)));
    @(negedge clk);
    start = 1'b0;
    bin   = W'($urandom);
  endtask

  task automatic wait_done(output bit ok, output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < TO) begin
      @(negedge clk);
      lat++;
    end
    ok = (done === 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_done: got %b want 0", done);
    end
    n_cmp++;
    if (bcd !== '0) begin
      n_err++;
      $display("FAIL reset_bcd: got %h want 000", bcd);
    end
`ifdef BCD_LEADING_BLANK_EN
    n_cmp++;
    if (blank !== 3'b110) begin
      n_err++;
      $display("FAIL reset_blank: got %b want 110", blank);
    end
`endif
  endtask

  // Bin = 0: Busy in cycles 1..9, Done only in cycle 9, idle again in 10.
  task automatic test_zero_latency;
    logic [BW-1:0] e;
    drive_start('0);
    for (int c = 1; c <= LAT + 1; c++) begin
      if (c > 1) @(negedge clk);
      n_cmp++;
      if (busy !== (c <= LAT)) begin
        n_err++;
        $display("FAIL zero_busy_c%0d: got %b want %b", c, busy, (c <= LAT));
      end
      n_cmp++;
      if (done !== (c == LAT)) begin
        n_err++;
        $display("FAIL zero_done_c%0d: got %b want %b", c, done, (c == LAT));
      end
      if (c == LAT && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (bcd !== e) begin
          n_err++;
          $display("FAIL zero_bcd: got %h want %h", bcd, e);
        end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_values;
    logic [W-1:0]  vals[6];
    logic [BW-1:0] e;
    bit            ok;
    int            lat;
    vals[0] = 8'd255;
    vals[1] = 8'd9;
    vals[2] = 8'd10;
    vals[3] = 8'd99;
    vals[4] = 8'd100;
    vals[5] = W'($urandom_range(0, 255));
    for (int i = 0; i < 6; i++) begin
      drive_start(vals[i]);
      wait_done(ok, lat);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok) begin
        n_err++;
        $display("FAIL val_timeout: bin=%0d got no Done want Done", vals[i]);
      end else begin
        if (bcd !== e) begin
          n_err++;
          $display("FAIL val_bcd: bin=%0d got %h want %h", vals[i], bcd, e);
        end
        n_cmp++;
        if (lat != LAT) begin
          n_err++;
          $display("FAIL val_latency: bin=%0d got %0d want %0d", vals[i], lat, LAT);
        end
        // Result must hold after the single-cycle Done pulse.
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || bcd !== e) begin
          n_err++;
          $display("FAIL val_hold: done=%b bcd=%h want done=0 bcd=%h", done, bcd, e);
        end
      end
    end
  endtask

  // Start held high, Bin changing every cycle: acceptances every W+2 cycles.
  task automatic test_back_to_back;
    logic [BW-1:0] e;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      n_cmp++;
      if (done !== ((c % (W + 2)) == W + 1)) begin
        n_err++;
        $display("FAIL b2b_done_c%0d: got %b want %b", c, done, ((c % (W + 2)) == W + 1));
      end
      if (done === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (bcd !== e) begin
          n_err++;
          $display("FAIL b2b_bcd_c%0d: got %h want %h", c, bcd, e);
        end
      end
      start = (c < 39);
      bin   = W'($urandom);
      if ((c % (W + 2)) == 0 && c < 39) begin
        exp_q.push_back(model_bcd(int'(bin)));
      end
    end
    start = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL b2b_pending: got %0d outstanding want 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  // Reset in cycle 4 of a conversion of 200: no Done, outputs cleared.
  task automatic test_reset_mid;
    bit            saw_done;
    bit            ok;
    int            lat;
    logic [BW-1:0] e;
    drive_start(8'd200);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== '0) begin
      n_err++;
      $display("FAIL mid_reset: busy=%b done=%b bcd=%h want 0 0 000", busy, done, bcd);
    end
    saw_done = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    n_cmp++;
    if (saw_done) begin
      n_err++;
      $display("FAIL mid_no_done: got activity after reset want none");
    end
    drive_start(8'd123);
    wait_done(ok, lat);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok || bcd !== e) begin
      n_err++;
      $display("FAIL mid_after: ok=%b bcd=%h want %h", ok, bcd, e);
    end
  endtask

  task automatic test_sweep;
    logic [BW-1:0] e;
    bit            ok;
    int            lat;
    for (int v = 0; v < 256; v++) begin
      drive_start(W'(v));
      wait_done(ok, lat);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || bcd !== e) begin
        n_err++;
        $display("FAIL sweep_%0d: ok=%b got %h want %h", v, ok, bcd, e);
      end
    end
  endtask

`ifdef BCD_LEADING_BLANK_EN
  task automatic test_blank;
    logic [W-1:0]  vals[4];
    logic [ND-1:0] want[4];
    logic [BW-1:0] e;
    bit            ok;
    int            lat;
    vals[0] = 8'd7;   want[0] = 3'b110;
    vals[1] = 8'd42;  want[1] = 3'b100;
    vals[2] = 8'd0;   want[2] = 3'b110;
    vals[3] = 8'd105; want[3] = 3'b000;
    for (int i = 0; i < 4; i++) begin
      drive_start(vals[i]);
      wait_done(ok, lat);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || blank !== want[i] || bcd !== e) begin
        n_err++;
        $display("FAIL blank_%0d: ok=%b blank=%b bcd=%h want %b %h",
                 vals[i], ok, blank, bcd, want[i], e);
      end
    end
  endtask
`endif

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b1;
    start = 1'b0;
    bin   = '0;
    test_reset();
    test_zero_latency();
    test_values();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
`ifdef BCD_LEADING_BLANK_EN
    test_blank();
`endif
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_bin2bcd.md
Name: seq_bin2bcd

Overview:
Sequential shift-and-add-3 (double-dabble) converter from an unsigned binary value to packed BCD digits. It sits directly upstream of the per-digit 7-segment decoders on the display path. It extends the 4-bit combinational compare/adjust/mux approach to arbitrary widths using a small handshake-driven FSM. Each BCD nibble output feeds one 7-segment decoder instance.

Parameters:
W, 8, binary input width in bits (legal range 4..16).
ND, 3, number of BCD output digits; must satisfy 10^ND > 2^W - 1 (checked by elaboration-time assertion).

Ports:
CLOCK_50  input  1  system clock; all logic on the rising edge.
Reset  input  1  synchronous, active-high reset.
Start  input  1  conversion request; sampled only in IDLE.
Bin  input  W  unsigned binary operand; captured on the accepted Start cycle.
Busy  output  1  high from the cycle after Start is accepted through the DONE cycle inclusive.
Done  output  1  single-cycle pulse; BCD is valid and updated in the same cycle.
BCD  output  4*ND  packed result; digit k is BCD[4k+3:4k], with digit 0 the least significant.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (Reset, sampled on the CLOCK_50 rising edge).
- Reset values: state = IDLE, Busy = 0, Done = 0, BCD = all zeros, internal shift/bit counter = 0.
- FSM states and transitions:
  - IDLE: when Start = 1, capture Bin into the binary shift register, clear the BCD scratch register, set the bit counter to W, and go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: each cycle, first add 3 to every scratch digit that is >= 5, then shift {scratch, binreg} left by 1 and decrement the counter. When the counter reaches 1 on that cycle, go to DONE.
  - DONE: drive the final scratch value onto the BCD output register, assert Done = 1, and return to IDLE.
- Latency: Start accepted in cycle 0. SHIFT occupies cycles 1..W. Done = 1 and the new BCD value are visible in cycle W+1. The earliest next Start is accepted in cycle W+2.
- Start while in SHIFT or DONE: ignored, not queued. Bin changes after capture have no effect.
- BCD holds its last result between conversions. It changes only in the DONE cycle or on reset.
- Reset mid-conversion: abort immediately, return to reset values, and do not emit a Done pulse.
- Arithmetic: add-3 correction is applied per 4-bit digit on unsigned values. Any digit >= 10 after a shift is an internal error, flagged by an assertion in simulation only.
- Bin = 0 converts to all-zero BCD with the same full latency; there is no early exit.
- Max input 2^W - 1 (255 at W = 8) converts to 2/5/5 (digits 2/1/0).

Optional Feature:
Macro BCD_LEADING_BLANK_EN.
- Defined: adds output port Blank [ND-1:0], registered and updated in the DONE cycle alongside BCD. Blank[k] = 1 when digit k and all higher digits are zero, for k >= 1. Blank[0] is always 0, so a value of zero displays as a single "0". Reset value is all ones except bit 0.
- Not defined: the port is absent and no blanking logic is generated.

Decomposition:
- Shared package bcd_pkg holds:
  - State encoding localparams S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2.
  - DIGIT_W = 4.
  - The constant ADD3_THRESH = 4'd5.
- One natural sub-module, bcd_add3: purely combinational, 4-bit in, 4-bit out, out = in + 3 when in >= 5. Instantiated ND times via generate inside seq_bin2bcd.

Test Plan:
1. Reset, then Bin = 8'd0 with a 1-cycle Start -> Busy high in cycles 1..9, Done pulses in cycle 9, BCD = 12'h000.
2. Bin = 8'd255 -> BCD = 12'h255 at the Done pulse. Bin = 8'd9 -> 12'h009. Bin = 8'd10 -> 12'h010.
3. Start held high continuously with Bin changing every cycle -> conversions accepted only in IDLE, back-to-back with a period of W+2 = 10 cycles. Each result matches the Bin sampled at its acceptance cycle.
4. Reset asserted in cycle 4 of a conversion of 8'd200 -> no Done pulse, BCD = 12'h000, Busy = 0. A following Start with 8'd123 -> 12'h123.
5. Exhaustive sweep of Bin over 0..255 -> every result equals the decimal digits of Bin, and no assertion fires.
6. With BCD_LEADING_BLANK_EN defined: Bin = 7 -> Blank = 3'b110; Bin = 42 -> Blank = 3'b100; Bin = 0 -> Blank = 3'b110; Bin = 105 -> Blank = 3'b000.
